// File: rtl/xevious_rom_loader.sv
// xevious_rom_loader
// Bridges the hps_io ROM download port to the xevious core download bus.
// Bytes inside the ROM window are forwarded with one cycle of latency and
// counted. The core is held in reset while a download is in progress and for
// HOLD_CYCLES clocks afterwards, and the loader reports whether the last image
// was complete.
//
// Optional feature macro: XEVS_LOADER_CHECKSUM_EN
//   When defined, a 16-bit wrapping sum of the accepted bytes is also compared
//   against EXPECT_SUM when a download ends.
//
// state | meaning
// IDLE  | no download seen since reset, core held in reset
// LOAD  | download active, bytes forwarded and counted, core held in reset
// HOLD  | download finished, core held in reset while hold_cnt runs down
// RUN   | core released, core_reset follows ext_reset
module xevious_rom_loader #(
  parameter logic [16:0] ROM_BYTES   = 17'h1_2000,
  parameter int          HOLD_CYCLES = 1024,
  parameter logic [15:0] EXPECT_SUM  = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ext_reset,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        loaded,
  output logic        load_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  // hold_cnt only ever holds HOLD_CYCLES-1 down to 0
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  localparam logic [17:0] ROM_COUNT = {1'b0, ROM_BYTES};
  localparam logic [24:0] ROM_LIMIT = {8'h00, ROM_BYTES};

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          dl_q;
  logic [17:0]   byte_cnt;
  logic [17:0]   byte_cnt_nxt;
  logic          ovf;
  logic          ovf_nxt;
  logic [HW-1:0] hold_cnt;

  logic dl_rise;
  logic dl_fall;
  logic in_load;
  logic addr_ok;
  logic wr_accept;
  logic wr_drop;
  logic hold_done;
  logic enter_load;
  logic enter_hold;
  logic bad_image;

`ifdef XEVS_LOADER_CHECKSUM_EN
  logic [15:0] sum;
  logic [15:0] sum_nxt;
`else
  logic unused_expect_sum;
  assign unused_expect_sum = ^EXPECT_SUM;
`endif

  // Edge detect, byte acceptance and the end-of-load verdict
  always_comb begin
    dl_rise   = ioctl_download & ~dl_q;
    dl_fall   = ~ioctl_download & dl_q;
    in_load   = (state == ST_LOAD);
    addr_ok   = (ioctl_addr < ROM_LIMIT);
    wr_accept = in_load & ioctl_wr & addr_ok;
    wr_drop   = in_load & ioctl_wr & ~addr_ok;
    hold_done = (hold_cnt == '0) & ~ext_reset;

    // A byte arriving in the same cycle as the falling edge still counts,
    // so the verdict is taken from the next-values, not the registers.
    byte_cnt_nxt = byte_cnt;
    if (wr_accept && (byte_cnt != '1)) begin
      byte_cnt_nxt = byte_cnt + 18'd1;
    end
    ovf_nxt = ovf | wr_drop;

`ifdef XEVS_LOADER_CHECKSUM_EN
    sum_nxt = sum;
    if (wr_accept) begin
      sum_nxt = sum + {8'h00, ioctl_dout};
    end
    bad_image = ovf_nxt | (byte_cnt_nxt != ROM_COUNT) | (sum_nxt != EXPECT_SUM);
`else
    bad_image = ovf_nxt | (byte_cnt_nxt != ROM_COUNT);
`endif
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (dl_rise) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (dl_fall) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (dl_rise)        state_nxt = ST_LOAD;
        else if (hold_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (dl_rise) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
    enter_load = (state != ST_LOAD) && (state_nxt == ST_LOAD);
    enter_hold = (state == ST_LOAD) && (state_nxt == ST_HOLD);
  end

  // Registered copy of ioctl_download used for edge detection
  always_ff @(posedge clk_sys) begin
    if (!reset_n) dl_q <= 1'b0;
    else          dl_q <= ioctl_download;
  end

  // State register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Per-download byte count and overflow flag, cleared on LOAD entry
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      ovf      <= 1'b0;
    end else if (enter_load) begin
      byte_cnt <= '0;
      ovf      <= 1'b0;
    end else if (in_load) begin
      byte_cnt <= byte_cnt_nxt;
      ovf      <= ovf_nxt;
    end
  end

`ifdef XEVS_LOADER_CHECKSUM_EN
  // Running byte sum of the image, cleared on LOAD entry
  always_ff @(posedge clk_sys) begin
    if (!reset_n)        sum <= '0;
    else if (enter_load) sum <= '0;
    else if (in_load)    sum <= sum_nxt;
  end
`endif

  // Post-download hold timer; ext_reset restarts the full hold period
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (enter_hold) begin
      hold_cnt <= HOLD_LOAD;
    end else if (state == ST_HOLD) begin
      if (ext_reset)              hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != '0)    hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Forward accepted bytes to the core download bus, one cycle later
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dn_addr <= '0;
      dn_data <= '0;
      dn_wr   <= 1'b0;
    end else begin
      dn_wr <= wr_accept;
      if (wr_accept) begin
        dn_addr <= ioctl_addr[16:0];
        dn_data <= ioctl_dout;
      end
    end
  end

  // Core reset: held everywhere except RUN, where it tracks ext_reset
  always_ff @(posedge clk_sys) begin
    if (!reset_n) core_reset <= 1'b1;
    else          core_reset <= (state_nxt == ST_RUN) ? ext_reset : 1'b1;
  end

  // Image status, updated only when a download completes
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      loaded   <= 1'b0;
      load_err <= 1'b0;
    end else if (enter_hold) begin
      loaded   <= ~bad_image;
      load_err <= bad_image;
    end
  end

endmodule

// File: tb/tb_xevious_rom_loader.sv
// Bench for xevious_rom_loader with a small ROM window and short hold period.
module tb_xevious_rom_loader;

  localparam int          ROM  = 48;
  localparam int          HOLD = 16;
  localparam logic [15:0] ESUM = 16'd1128;  // sum of bytes 0..47

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ext_reset;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        loaded;
  logic        load_err;

  xevious_rom_loader #(
    .ROM_BYTES  (17'(ROM)),
    .HOLD_CYCLES(HOLD),
    .EXPECT_SUM (ESUM)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ext_reset     (ext_reset),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .core_reset    (core_reset),
    .loaded        (loaded),
    .load_err      (load_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    int nbytes;
    bit oob;
    bit corrupt;
    bit dup;
    bit fall_wr;
    bit exp_loaded;
    bit exp_err;
  } row_t;

  wr_t  wq[$];
  row_t rows[5];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   loading = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drive one cycle; a write is forwarded iff the loader is loading and the
  // address lies inside the ROM window.
  task automatic step(input logic dl, input logic wr, input logic [24:0] a, input logic [7:0] d);
    bit acc;
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = a;
    ioctl_dout     = d;
    acc = loading && wr && (a < 25'(ROM));
    tick();
    chk("dn_wr", dn_wr, acc);
    if (acc) begin
      chk("dn_addr", dn_addr, a[16:0]);
      chk("dn_data", dn_data, d);
    end
  endtask

  // Reference verdict over the whole write list
  function automatic bit model_err();
    int          cnt = 0;
    bit          oob = 0;
    logic [15:0] s   = 0;
    foreach (wq[i]) begin
      if (wq[i].a < 25'(ROM)) begin
        cnt++;
        s = s + 16'(wq[i].d);
      end else begin
        oob = 1;
      end
    end
`ifdef XEVS_LOADER_CHECKSUM_EN
    return oob || (cnt != ROM) || (s != ESUM);
`else
    return oob || (cnt != ROM);
`endif
  endfunction

  task automatic build_image(input int nbytes, input bit oob, input bit corrupt, input bit dup);
    wq.delete();
    for (int a = 0; a < nbytes; a++) wq.push_back('{25'(a), 8'(a)});
    if (corrupt) wq[5].d = wq[5].d + 8'd1;
    if (dup) wq.push_back('{25'(0), 8'h00});
    if (oob) wq.push_back('{25'(ROM), 8'hAA});
  endtask

  // Full download of wq, then measure the hold period. ext_at>0 asserts
  // ext_reset for one cycle at that many cycles after the falling edge.
  task automatic run_download(input bit fall_wr, input int ext_at);
    int n;
    bit done;
    int exp_len;
    loading = 0;
    step(1'b1, 1'b0, '0, '0);
    chk("core_reset_load", core_reset, 1);
    loading = 1;
    for (int i = 0; i < wq.size(); i++) begin
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 25'($urandom), 8'($urandom));
      if (fall_wr && i == wq.size() - 1) step(1'b0, 1'b1, wq[i].a, wq[i].d);
      else                               step(1'b1, 1'b1, wq[i].a, wq[i].d);
    end
    if (!fall_wr || wq.size() == 0) step(1'b0, 1'b0, '0, '0);
    loading = 0;
    exp_len = (ext_at > 0) ? ext_at + HOLD : HOLD;
    n = 0;
    done = 0;
    while (!done && n < 4 * HOLD) begin
      n++;
      ext_reset = (n == ext_at);
      step(1'b0, 1'b0, '0, '0);
      if (!core_reset) done = 1;
    end
    ext_reset = 0;
    chk("hold_len", n, exp_len);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bit exp_err;
    bit fw;

    rows[0] = '{ROM,     0, 0, 0, 0, 1, 0};
    rows[1] = '{ROM - 1, 0, 0, 0, 1, 0, 1};
    rows[2] = '{ROM,     1, 0, 0, 0, 0, 1};
    rows[3] = '{ROM,     0, 0, 1, 1, 0, 1};
`ifdef XEVS_LOADER_CHECKSUM_EN
    rows[4] = '{ROM,     0, 1, 0, 0, 0, 1};
`else
    rows[4] = '{ROM,     0, 1, 0, 0, 1, 0};
`endif

    reset_n = 0;
    ioctl_download = 0;
    ioctl_wr = 0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ext_reset = 0;
    repeat (3) tick();
    chk("rst_dn_addr", dn_addr, 0);
    chk("rst_dn_data", dn_data, 0);
    chk("rst_dn_wr", dn_wr, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_loaded", loaded, 0);
    chk("rst_load_err", load_err, 0);
    reset_n = 1;
    step(1'b0, 1'b1, 25'd3, 8'h44);  // write in IDLE is ignored
    chk("idle_core_reset", core_reset, 1);

    // Table-driven downloads
    for (int r = 0; r < 5; r++) begin
      build_image(rows[r].nbytes, rows[r].oob, rows[r].corrupt, rows[r].dup);
      run_download(rows[r].fall_wr, 0);
      chk($sformatf("row%0d_loaded", r), loaded, rows[r].exp_loaded);
      chk($sformatf("row%0d_load_err", r), load_err, rows[r].exp_err);
    end

    // Randomized images against the reference verdict
    for (int k = 0; k < 8; k++) begin
      bit keep = $urandom_range(0, 1);
      wq.delete();
      for (int a = 0; a < ROM; a++) wq.push_back('{25'(a), keep ? 8'(a) : 8'($urandom)});
      if ($urandom_range(0, 3) == 0) wq.delete($urandom_range(0, ROM - 1));
      if ($urandom_range(0, 3) == 0)
        wq.push_back('{$urandom_range(0, 1) ? 25'h1FF_FFFF : 25'(ROM + $urandom_range(0, 1000)), 8'h5A});
      exp_err = model_err();
      fw = $urandom_range(0, 1);
      run_download(fw, 0);
      chk($sformatf("rand%0d_load_err", k), load_err, exp_err);
      chk($sformatf("rand%0d_loaded", k), loaded, !exp_err);
    end

    // ext_reset during HOLD restarts the full hold period
    build_image(ROM, 0, 0, 0);
    run_download(0, 3);
    chk("hold_ext_loaded", loaded, 1);

    // In RUN: writes ignored, ext_reset follows with one cycle of latency
    step(1'b0, 1'b1, 25'd2, 8'h77);
    chk("run_core_reset", core_reset, 0);
    ext_reset = 1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, '0);
      chk($sformatf("ext_pulse%0d", i), core_reset, 1);
    end
    ext_reset = 0;
    step(1'b0, 1'b0, '0, '0);
    chk("ext_release", core_reset, 0);

    // reset_n in the middle of a download aborts it
    loading = 0;
    step(1'b1, 1'b0, '0, '0);
    loading = 1;
    step(1'b1, 1'b1, 25'd0, 8'h11);
    step(1'b1, 1'b1, 25'd1, 8'h22);
    loading = 0;
    reset_n = 0;
    ioctl_download = 0;
    ioctl_wr = 0;
    tick();
    chk("abort_dn_wr", dn_wr, 0);
    chk("abort_dn_addr", dn_addr, 0);
    chk("abort_dn_data", dn_data, 0);
    chk("abort_core_reset", core_reset, 1);
    chk("abort_loaded", loaded, 0);
    chk("abort_load_err", load_err, 0);
    reset_n = 1;
    step(1'b0, 1'b1, 25'd4, 8'h33);
    chk("abort_idle_core_reset", core_reset, 1);
    build_image(ROM, 0, 0, 0);
    run_download(1, 0);
    chk("reload_loaded", loaded, 1);
    chk("reload_load_err", load_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
